// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and default width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full-adder cell, time-multiplexed by serial_add_ctrl.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one result bit per cycle, LSB first
// DONE  | result presented until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,output logic            ovf
`endif
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  FullAdder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          // wrap on the final bit so the counter never passes WIDTH-1
          cnt    <= last_bit ? '0 : cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // carry register holds the carry into the MSB during the last RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ovf <= 1'b0;
    else if (state == RUN && last_bit) ovf <= carry ^ fa_cout;
  end
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = res_sr;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and scoreboarded bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,.ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with in_ready high; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tc,
                        output logic [W-1:0] s, output logic c, output int lat, output logic run_ok);
    a = ta; b = tb_op; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'b1;
    lat = -1;
    run_ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) run_ok = busy & ~in_ready & ~out_valid;
      if (out_valid) begin
        lat = i - 1;
        break;
      end
    end
    s = sum; c = cout;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_accept_out_valid", 32'(out_valid), 32'd0);
    chk("post_accept_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Continuous operation with in_valid/out_ready held high; results must come every W+2 cycles.
  task automatic stream(input int n, input bit rnd);
    logic [W-1:0] ta [3];
    logic [W-1:0] tbv [3];
    logic         tcv [3];
    logic [W:0]   exp_q [$];
    logic [W:0]   e;
    int issued = 0, got = 0, last = -1, cyc = 0;
    logic acc;
    ta[0] = 8'h01; tbv[0] = 8'h02; tcv[0] = 1'b0;
    ta[1] = 8'hAA; tbv[1] = 8'h55; tcv[1] = 1'b1;
    ta[2] = 8'h7E; tbv[2] = 8'h0F; tcv[2] = 1'b1;
    out_ready = 1'b1;
    if (rnd) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
    else begin a = ta[0]; b = tbv[0]; cin = tcv[0]; end
    in_valid = 1'b1;
    while (got < n && cyc < n * 12 + 50) begin
      acc = in_ready & in_valid;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("stream_unexpected_result", 32'(sum), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk(rnd ? "rand_sum" : "b2b_sum", {23'd0, cout, sum}, {23'd0, e});
        end
        if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        got++;
      end
      if (acc) exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      @(posedge clk); #1;
      if (acc) begin
        issued++;
        if (issued >= n) in_valid = 1'b0;
        else if (rnd) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
        else begin a = ta[issued]; b = tbv[issued]; cin = tcv[issued]; end
      end
      @(negedge clk);
      cyc++;
    end
    if (got < n) chk("stream_timeout_results", 32'(got), 32'(n));
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] s;
    logic         c;
    int           lat;
    logic         run_ok;

    // reset held with noisy inputs
    in_valid = 1'b1; out_ready = 1'b1; a = 8'h5A; b = 8'hC3; cin = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // basic add
    run_op(8'h3C, 8'h25, 1'b0, s, c, lat, run_ok);
    chk("basic_run_state", 32'(run_ok), 32'd1);
    chk("basic_latency", 32'(lat), 32'(W));
    chk("basic_sum", 32'(s), 32'h61);
    chk("basic_cout", 32'(c), 32'd0);
    take_result();

    // wrap-around
    run_op(8'hFF, 8'h00, 1'b1, s, c, lat, run_ok);
    chk("wrap_latency", 32'(lat), 32'(W));
    chk("wrap_sum", 32'(s), 32'h00);
    chk("wrap_cout", 32'(c), 32'd1);
    take_result();

    // backpressure with a competing request
    run_op(8'h80, 8'h80, 1'b0, s, c, lat, run_ok);
    chk("bp_sum0", 32'(s), 32'h00);
    chk("bp_cout0", 32'(c), 32'd1);
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum_hold", {23'd0, cout, sum}, 32'h100);
    end
    in_valid = 1'b0;
    take_result();
    chk("bp_no_stray_accept", 32'(busy), 32'd0);

    // asynchronous reset mid-RUN
    a = 8'hFF; b = 8'h00; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SERIAL_ADD_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, s, c, lat, run_ok);
    chk("ovf_7f_01", 32'(ovf), 32'd1);
    take_result();
    run_op(8'h80, 8'hFF, 1'b0, s, c, lat, run_ok);
    chk("ovf_80_ff", 32'(ovf), 32'd1);
    take_result();
    run_op(8'h10, 8'h20, 1'b0, s, c, lat, run_ok);
    chk("ovf_10_20", 32'(ovf), 32'd0);
    chk("ovf_10_20_sum", 32'(s), 32'h30);
    take_result();
`endif

    stream(3, 1'b0);
    stream(1000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
